// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch and accepted-fetch counter.
// Redirects come from EX (taken branch) or ID (jump). Either redirect flushes IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
  logic [XLEN-1:0] if_id_pc4_q, if_id_pc4_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jump_target;
  logic            jump_qual;

  assign pc_plus4    = pc_q + XLEN'(4);
  assign jump_target = {if_id_pc4_q[31:28], jump_index, 2'b00};
  // A jump only counts when the instruction decoding it in ID is real.
  assign jump_qual   = jump & if_id_valid_q;

  // Next-state selection: branch > jump > stall > sequential fetch.
  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    if (branch_taken) begin
      pc_d          = branch_target;
      if_id_instr_d = '0;
      if_id_pc4_d   = '0;
      if_id_valid_d = 1'b0;
    end else if (jump_qual) begin
      pc_d          = jump_target;
      if_id_instr_d = '0;
      if_id_pc4_d   = '0;
      if_id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d          = pc_plus4;
      if_id_instr_d = imem_data;
      if_id_pc4_d   = pc_plus4;
      if_id_valid_d = 1'b1;
      fetch_count_d = fetch_count_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= '0;
      if_id_pc4_q   <= '0;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction-memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory: addr 0 holds addi, 0x100 holds an all-zero word, else 0xA5000000 ^ addr.
  always_comb begin
    if (imem_addr == 32'h0)        imem_data = 32'h2008_0002;
    else if (imem_addr == 32'h100) imem_data = 32'h0;
    else                           imem_data = 32'hA500_0000 ^ imem_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_index = 26'h0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    branch_taken = 1'b1; branch_target = tgt;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    jump = 1'b1; jump_index = 26'h3F;
    tick(); tick();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp %h", imem_addr, 32'h0); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp %h", if_id_instr, 32'h0); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp %h", if_id_pc4, 32'h0); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp %b", if_id_valid, 1'b0); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_count got %h exp %h", fetch_count, 32'h0); end
    idle();
  endtask

  task automatic test_sequential();
    tick();
    checks++; if (if_id_instr !== 32'h2008_0002) begin errors++; $display("FAIL seq1_instr got %h exp %h", if_id_instr, 32'h2008_0002); end
    checks++; if (if_id_pc4 !== 32'h4) begin errors++; $display("FAIL seq1_pc4 got %h exp %h", if_id_pc4, 32'h4); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL seq1_valid got %b exp %b", if_id_valid, 1'b1); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq1_addr got %h exp %h", imem_addr, 32'h4); end
    tick(); tick();
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL seq3_addr got %h exp %h", imem_addr, 32'hC); end
    checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL seq3_count got %h exp %h", fetch_count, 32'd3); end
    checks++; if (if_id_instr !== 32'hA500_0008) begin errors++; $display("FAIL seq3_instr got %h exp %h", if_id_instr, 32'hA500_0008); end
  endtask

  task automatic test_stall();
    tick(); tick();
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL stl_pre_addr got %h exp %h", imem_addr, 32'h14); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL stl_addr got %h exp %h", imem_addr, 32'h14); end
      checks++; if (if_id_instr !== 32'hA500_0010 || if_id_pc4 !== 32'h14 || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL stl_ifid got %h/%h/%b exp %h/%h/%b", if_id_instr, if_id_pc4, if_id_valid, 32'hA500_0010, 32'h14, 1'b1);
      end
      checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL stl_count got %h exp %h", fetch_count, 32'd5); end
    end
    stall = 1'b0;
    tick();
    checks++; if (if_id_instr !== 32'hA500_0014 || if_id_pc4 !== 32'h18) begin
      errors++; $display("FAIL stl_resume got %h/%h exp %h/%h", if_id_instr, if_id_pc4, 32'hA500_0014, 32'h18);
    end
    checks++; if (fetch_count !== 32'd6) begin errors++; $display("FAIL stl_resume_count got %h exp %h", fetch_count, 32'd6); end
  endtask

  task automatic test_jump();
    redirect(32'h58);
    checks++; if (imem_addr !== 32'h58 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      errors++; $display("FAIL br_flush got %h/%b/%h exp %h/%b/%h", imem_addr, if_id_valid, if_id_instr, 32'h58, 1'b0, 32'h0);
    end
    tick();
    checks++; if (if_id_pc4 !== 32'h5C || if_id_valid !== 1'b1 || fetch_count !== 32'd7) begin
      errors++; $display("FAIL jmp_setup got %h/%b/%h exp %h/%b/%h", if_id_pc4, if_id_valid, fetch_count, 32'h5C, 1'b1, 32'd7);
    end
    jump = 1'b1; jump_index = 26'h000000D; stall = 1'b1;
    tick();
    idle();
    checks++; if (imem_addr !== 32'h34) begin errors++; $display("FAIL jmp_addr got %h exp %h", imem_addr, 32'h34); end
    checks++; if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc4 !== 32'h0) begin
      errors++; $display("FAIL jmp_flush got %h/%b/%h exp %h/%b/%h", if_id_instr, if_id_valid, if_id_pc4, 32'h0, 1'b0, 32'h0);
    end
    checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL jmp_count got %h exp %h", fetch_count, 32'd7); end
    tick();
    checks++; if (if_id_instr !== 32'hA500_0034 || if_id_pc4 !== 32'h38 || imem_addr !== 32'h38) begin
      errors++; $display("FAIL jmp_latency got %h/%h/%h exp %h/%h/%h", if_id_instr, if_id_pc4, imem_addr, 32'hA500_0034, 32'h38, 32'h38);
    end
  endtask

  task automatic test_jump_invalid();
    redirect(32'h40);
    jump = 1'b1; jump_index = 26'h000000D;
    tick();
    idle();
    checks++; if (imem_addr !== 32'h44) begin errors++; $display("FAIL jinv_addr got %h exp %h", imem_addr, 32'h44); end
    checks++; if (if_id_instr !== 32'hA500_0040 || if_id_valid !== 1'b1 || fetch_count !== 32'd9) begin
      errors++; $display("FAIL jinv_ifid got %h/%b/%h exp %h/%b/%h", if_id_instr, if_id_valid, fetch_count, 32'hA500_0040, 1'b1, 32'd9);
    end
  endtask

  task automatic test_branch_priority();
    branch_taken = 1'b1; branch_target = 32'h60; jump = 1'b1; jump_index = 26'h3FF; stall = 1'b1;
    tick();
    idle();
    checks++; if (imem_addr !== 32'h60) begin errors++; $display("FAIL bpri_addr got %h exp %h", imem_addr, 32'h60); end
    checks++; if (if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0 || fetch_count !== 32'd9) begin
      errors++; $display("FAIL bpri_flush got %h/%h/%b/%h exp 0/0/0/%h", if_id_instr, if_id_pc4, if_id_valid, fetch_count, 32'd9);
    end
  endtask

  task automatic test_zero_word();
    redirect(32'h100);
    tick();
    checks++; if (if_id_instr !== 32'h0 || if_id_valid !== 1'b1 || fetch_count !== 32'd10) begin
      errors++; $display("FAIL zero_word got %h/%b/%h exp %h/%b/%h", if_id_instr, if_id_valid, fetch_count, 32'h0, 1'b1, 32'd10);
    end
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    tick();
    checks++; if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0) begin
      errors++; $display("FAIL wrap_pc got %h/%h exp %h/%h", imem_addr, if_id_pc4, 32'h0, 32'h0);
    end
    checks++; if (if_id_instr !== 32'h5AFF_FFFC || if_id_valid !== 1'b1 || fetch_count !== 32'd11) begin
      errors++; $display("FAIL wrap_ifid got %h/%b/%h exp %h/%b/%h", if_id_instr, if_id_valid, fetch_count, 32'h5AFF_FFFC, 1'b1, 32'd11);
    end
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1 release dut.fetch_count_q;
    tick();
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL wrap_count got %h exp %h", fetch_count, 32'h0); end
  endtask

  task automatic test_reset_midstream();
    tick();
    reset = 1'b1; jump = 1'b1; jump_index = 26'h1;
    tick();
    idle();
    checks++; if (imem_addr !== 32'h0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0 || fetch_count !== 32'h0) begin
      errors++; $display("FAIL mid_rst got %h/%h/%h/%b/%h exp all zero", imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count);
    end
    tick();
    checks++; if (if_id_instr !== 32'h2008_0002 || if_id_pc4 !== 32'h4 || fetch_count !== 32'd1) begin
      errors++; $display("FAIL mid_refetch got %h/%h/%h exp %h/%h/%h", if_id_instr, if_id_pc4, fetch_count, 32'h2008_0002, 32'h4, 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_jump_invalid();
    test_branch_priority();
    test_zero_word();
    test_wrap();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h00000000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_addr  output  32  byte address to instruction memory; equal to the current PC, combinational from the PC register.
REQ-005 imem_data  input  32  instruction word returned combinationally by instruction memory for imem_addr.
REQ-006 stall  input  1  hazard-unit hold request; freezes PC and IF/ID.
REQ-007 branch_taken  input  1  taken branch resolved downstream (EX); redirect plus flush.
REQ-008 branch_target  input  32  byte target of the taken branch.
REQ-009 jump  input  1  j decoded in ID from if_id_instr; redirect plus flush.
REQ-010 jump_index  input  26  instr[25:0] of the jump in ID.
REQ-011 if_id_instr  output  32  IF/ID latched instruction; 0 (nop) when invalid.
REQ-012 if_id_pc4  output  32  IF/ID latched PC+4 of if_id_instr.
REQ-013 if_id_valid  output  1  IF/ID holds a real fetched instruction.
REQ-014 fetch_count  output  32  count of instructions accepted into IF/ID.

Function
REQ-015 The PC register SHALL be 32 bits, and imem_addr SHALL equal PC with no added latency.
REQ-016 Sequential next PC SHALL be PC+4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
REQ-017 Jump target SHALL be {if_id_pc4[31:28], jump_index, 2'b00}.
REQ-018 jump SHALL be ignored when if_id_valid=0.
REQ-019 Per-edge priority, highest first: reset > branch_taken > jump (qualified) > stall > normal fetch.
REQ-020 On branch_taken, the block SHALL load PC<=branch_target, if_id_instr<=0, if_id_pc4<=0 and if_id_valid<=0, regardless of jump or stall.
REQ-021 On a qualified jump without branch_taken, the block SHALL load PC<=jump target and SHALL flush IF/ID as in REQ-020, regardless of stall.
REQ-022 On stall without redirect, PC, if_id_instr, if_id_pc4, if_id_valid and fetch_count SHALL hold their values.
REQ-023 On normal fetch, the block SHALL load if_id_instr<=imem_data, if_id_pc4<=PC+4, if_id_valid<=1 and PC<=PC+4.
REQ-024 fetch_count SHALL increment by 1 (wrapping) only on a normal-fetch edge; flushes, stalls and reset do not increment it.
REQ-025 A fetched all-zero word SHALL be latched with if_id_valid=1 and counted; nop is not special-cased.
REQ-026 Redirect latency: the target address SHALL appear on imem_addr in the cycle after the redirect edge, and its instruction SHALL reach IF/ID one edge later.
REQ-027 No combinational path SHALL exist from stall, branch_taken or jump to any IF/ID output.

Reset
REQ-028 While reset=1 at a rising edge: PC<=RESET_PC, if_id_instr<=0, if_id_pc4<=0, if_id_valid<=0, fetch_count<=0.
REQ-029 Reset SHALL override any simultaneous stall, branch_taken or jump.
REQ-030 Reset mid-stream SHALL discard IF/ID content, with no partial update.
REQ-031 The first fetch SHALL be from RESET_PC on the first edge after reset deasserts.

Verification
REQ-032 Reset then 3 free edges, imem_data=0x20080002 at 0 -> after edge 1: if_id_instr=0x20080002, if_id_pc4=4, if_id_valid=1; after edge 3: imem_addr=0x0C, fetch_count=3.
REQ-033 stall=1 for 2 edges with PC=0x14 -> imem_addr stays 0x14; IF/ID and fetch_count unchanged; fetch resumes at 0x14 once stall drops.
REQ-034 jump=1, jump_index=0x000000D, if_id_pc4=0x5C, if_id_valid=1 -> next imem_addr=0x34; if_id_instr=0, if_id_valid=0; count unchanged.
REQ-035 branch_taken=1, branch_target=0x60, jump=1 and stall=1 on the same edge -> imem_addr=0x60; IF/ID flushed.
REQ-036 jump=1 with if_id_valid=0 -> ignored; imem_addr advances by 4.
REQ-037 PC=0xFFFFFFFC, free edge -> imem_addr=0, if_id_pc4=0; fetch_count=0xFFFFFFFF plus one fetch -> 0.
